// File: rtl/aead_ctrl_param_if.sv
// Handshake and datapath-control bundle between the AEAD controller and its surroundings.
// The controller uses the master modport; pre/post-processor and datapath use slave.
interface aead_ctrl_param_if #(
  parameter int CTR_W = 4
);
  logic             key_update;
  logic             key_valid;
  logic             key_ready;
  logic             bdi_valid;
  logic             bdi_ready;
  logic             bdi_eot;
  logic             bdi_eoi;
  logic [3:0]       bdi_type;
  logic [2:0]       bdi_size;
  logic             decrypt;
  logic             bdo_valid;
  logic             bdo_ready;
  logic             bdo_last;
  logic             end_of_block;
  logic             msg_auth_valid;
  logic             msg_auth_ready;
  logic             msg_auth;
  logic             tag_word_eq;
  logic             tls_done;
  logic             perm_done;
  logic             start_tls;
  logic             start_perm;
  logic             en_key;
  logic             en_bdi;
  logic             clr_bdi;
  logic             en_pad;
  logic             en_ext_state;
  logic             tweak_sel;
  logic             sel_tag;
  logic [1:0]       state_sel;
  logic [1:0]       dom_sep;
  logic [CTR_W-1:0] word_idx;

  modport master (
    input  key_update, key_valid, bdi_valid, bdi_eot, bdi_eoi, bdi_type, bdi_size,
           decrypt, bdo_ready, msg_auth_ready, tag_word_eq, tls_done, perm_done,
    output key_ready, bdi_ready, bdo_valid, bdo_last, end_of_block, msg_auth_valid,
           msg_auth, start_tls, start_perm, en_key, en_bdi, clr_bdi, en_pad,
           en_ext_state, tweak_sel, sel_tag, state_sel, dom_sep, word_idx
  );

  modport slave (
    output key_update, key_valid, bdi_valid, bdi_eot, bdi_eoi, bdi_type, bdi_size,
           decrypt, bdo_ready, msg_auth_ready, tag_word_eq, tls_done, perm_done,
    input  key_ready, bdi_ready, bdo_valid, bdo_last, end_of_block, msg_auth_valid,
           msg_auth, start_tls, start_perm, en_key, en_bdi, clr_bdi, en_pad,
           en_ext_state, tweak_sel, sel_tag, state_sel, dom_sep, word_idx
  );
endinterface

// File: rtl/aead_ctrl_param.sv
// Parametrised Spook-style AEAD control FSM: key/nonce load, TLS init/tag, block-wise
// absorb/encrypt/decrypt through the permutation, and in-block tag verification.
module aead_ctrl_param #(
  parameter int KEY_WORDS   = 4,
  parameter int NPUB_WORDS  = 4,
  parameter int BLOCK_WORDS = 8,
  parameter int TAG_WORDS   = 4,
  parameter int CTR_W       = 4
) (
  input  logic                clk,
  input  logic                rst,
  aead_ctrl_param_if.master   bus
);

  typedef enum logic [3:0] {
    IDLE, LOAD_KEY, LOAD_NPUB, TLS_INIT, WAIT_TLS_INIT, PERM_INIT, ABSORB, WAIT_PERM,
    UPDATE, WRITE, PRE_TAG, TLS_TAG, WAIT_TLS_TAG, VERIFY_TAG, OUT_TAG, AUTH
  } state_t;

  localparam logic [CTR_W-1:0] KEY_LAST   = CTR_W'(KEY_WORDS - 1);
  localparam logic [CTR_W-1:0] NPUB_LAST  = CTR_W'(NPUB_WORDS - 1);
  localparam logic [CTR_W-1:0] BLOCK_LAST = CTR_W'(BLOCK_WORDS - 1);
  localparam logic [CTR_W-1:0] TAG_LAST   = CTR_W'(TAG_WORDS - 1);
  localparam logic [CTR_W-1:0] CTR_ONE    = CTR_W'(1);

  state_t           state;
  logic [CTR_W-1:0] ctr;
  logic [CTR_W-1:0] wr_last;
  logic             decrypt_r;
  logic             eoi_r;
  logic             eot_r;
  logic             partial_r;
  logic             is_ad_r;
  logic             first_r;
  logic             match_r;

  assign bus.word_idx = ctr;

  // NOTE: every register in a clocked block is assigned with <= so all of them update
  // from the same pre-edge values; blocking assignments here would create ordering bugs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ctr       <= '0;
      wr_last   <= '0;
      decrypt_r <= 1'b0;
      eoi_r     <= 1'b0;
      eot_r     <= 1'b0;
      partial_r <= 1'b0;
      is_ad_r   <= 1'b0;
      first_r   <= 1'b1;
      match_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ctr <= '0;
          if (bus.key_update && bus.key_valid) state <= LOAD_KEY;
          else if (bus.bdi_valid)              state <= LOAD_NPUB;
        end
        LOAD_KEY: begin
          if (bus.key_valid) begin
            if (ctr == KEY_LAST) begin
              ctr   <= '0;
              state <= LOAD_NPUB;
            end else begin
              ctr <= ctr + CTR_ONE;
            end
          end
        end
        LOAD_NPUB: begin
          if (bus.bdi_valid) begin
            if (ctr == NPUB_LAST) begin
              ctr       <= '0;
              decrypt_r <= bus.decrypt;
              eoi_r     <= bus.bdi_eoi;
              state     <= TLS_INIT;
            end else begin
              ctr <= ctr + CTR_ONE;
            end
          end
        end
        TLS_INIT: state <= WAIT_TLS_INIT;
        WAIT_TLS_INIT: begin
          if (bus.tls_done) state <= PERM_INIT;
        end
        PERM_INIT: begin
          first_r   <= 1'b1;
          eot_r     <= 1'b0;
          partial_r <= 1'b0;
          state     <= eoi_r ? PRE_TAG : ABSORB;
        end
        ABSORB: begin
          if (bus.bdi_valid) begin
            is_ad_r <= (bus.bdi_type == 4'b0001);
            if (bus.bdi_eot) partial_r <= (bus.bdi_size != 3'd0);
            if (ctr == BLOCK_LAST || bus.bdi_eot) begin
              eot_r   <= bus.bdi_eot;
              eoi_r   <= bus.bdi_eoi;
              wr_last <= ctr;
              state   <= WAIT_PERM;
            end else begin
              ctr <= ctr + CTR_ONE;
            end
          end
        end
        WAIT_PERM: begin
          if (bus.perm_done) state <= UPDATE;
        end
        UPDATE: begin
          ctr       <= '0;
          partial_r <= 1'b0;
          if (is_ad_r) begin
            state <= eoi_r ? PRE_TAG : ABSORB;
          end else begin
            first_r <= 1'b0;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (bus.bdo_ready) begin
            if (ctr == wr_last) begin
              ctr   <= '0;
              state <= eoi_r ? PRE_TAG : ABSORB;
            end else begin
              ctr <= ctr + CTR_ONE;
            end
          end
        end
        PRE_TAG: begin
          if (bus.perm_done) state <= TLS_TAG;
        end
        TLS_TAG: state <= WAIT_TLS_TAG;
        WAIT_TLS_TAG: begin
          if (bus.tls_done) begin
            match_r <= 1'b1;
            state   <= decrypt_r ? VERIFY_TAG : OUT_TAG;
          end
        end
        OUT_TAG: begin
          if (bus.bdo_ready) begin
            if (ctr == TAG_LAST) begin
              ctr   <= '0;
              state <= IDLE;
            end else begin
              ctr <= ctr + CTR_ONE;
            end
          end
        end
        VERIFY_TAG: begin
          if (bus.bdi_valid) begin
            match_r <= match_r & bus.tag_word_eq;
            if (ctr == TAG_LAST) begin
              ctr   <= '0;
              state <= AUTH;
            end else begin
              ctr <= ctr + CTR_ONE;
            end
          end
        end
        AUTH: begin
          if (bus.msg_auth_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    bus.key_ready      = 1'b0;
    bus.bdi_ready      = 1'b0;
    bus.bdo_valid      = 1'b0;
    bus.bdo_last       = 1'b0;
    bus.end_of_block   = 1'b0;
    bus.msg_auth_valid = 1'b0;
    bus.msg_auth       = 1'b0;
    bus.start_tls      = 1'b0;
    bus.start_perm     = 1'b0;
    bus.en_key         = 1'b0;
    bus.en_bdi         = 1'b0;
    bus.clr_bdi        = 1'b0;
    bus.en_pad         = 1'b0;
    bus.en_ext_state   = 1'b0;
    bus.tweak_sel      = 1'b0;
    bus.sel_tag        = 1'b0;
    bus.state_sel      = 2'b00;
    bus.dom_sep        = 2'b00;
    case (state)
      IDLE: bus.clr_bdi = 1'b1;
      LOAD_KEY: begin
        bus.key_ready = 1'b1;
        bus.en_key    = bus.key_valid;
      end
      LOAD_NPUB: begin
        bus.bdi_ready = 1'b1;
        bus.en_bdi    = bus.bdi_valid;
      end
      TLS_INIT: bus.start_tls = 1'b1;
      PERM_INIT: begin
        bus.start_perm   = 1'b1;
        bus.en_ext_state = 1'b1;
        bus.clr_bdi      = 1'b1;
      end
      ABSORB: begin
        bus.bdi_ready = 1'b1;
        bus.en_bdi    = bus.bdi_valid;
        bus.en_pad    = bus.bdi_valid;
      end
      UPDATE: begin
        bus.start_perm   = 1'b1;
        bus.en_ext_state = 1'b1;
        bus.clr_bdi      = 1'b1;
        // AD blocks never carry the first-message-block flag.
        if (is_ad_r) begin
          bus.state_sel = 2'b01;
          bus.dom_sep   = {eot_r & partial_r, 1'b0};
        end else begin
          bus.state_sel = decrypt_r ? 2'b10 : 2'b11;
          bus.dom_sep   = {eot_r & partial_r, first_r};
        end
      end
      WRITE: begin
        bus.bdo_valid    = 1'b1;
        bus.bdo_last     = (ctr == wr_last);
        bus.end_of_block = (ctr == wr_last) && eot_r;
      end
      TLS_TAG: begin
        bus.start_tls = 1'b1;
        bus.tweak_sel = 1'b1;
      end
      WAIT_TLS_TAG: bus.tweak_sel = 1'b1;
      OUT_TAG: begin
        bus.sel_tag      = 1'b1;
        bus.bdo_valid    = 1'b1;
        bus.bdo_last     = (ctr == TAG_LAST);
        bus.end_of_block = (ctr == TAG_LAST);
      end
      VERIFY_TAG: begin
        bus.bdi_ready = 1'b1;
        bus.sel_tag   = 1'b1;
      end
      AUTH: begin
        bus.msg_auth_valid = 1'b1;
        bus.msg_auth       = match_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aead_ctrl_param.sv
// Directed self-checking bench for aead_ctrl_param with a simple latency model of the
// TLS and permutation units.
module tb_aead_ctrl_param;
  localparam int CTR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aead_ctrl_param_if #(.CTR_W(CTR_W)) bus();

  aead_ctrl_param #(
    .KEY_WORDS(4), .NPUB_WORDS(4), .BLOCK_WORDS(8), .TAG_WORDS(4), .CTR_W(CTR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [CTR_W-1:0] idx;
    logic             last;
    logic             eob;
    logic             tag;
  } xfer_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Latency model: done is a level that drops for a few cycles after each start pulse.
  int perm_cnt;
  int tls_cnt;
  bit perm_hold = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      perm_cnt <= 0;
      tls_cnt  <= 0;
    end else begin
      if (bus.start_perm)    perm_cnt <= 3;
      else if (perm_cnt != 0) perm_cnt <= perm_cnt - 1;
      if (bus.start_tls)     tls_cnt <= 2;
      else if (tls_cnt != 0) tls_cnt <= tls_cnt - 1;
    end
  end
  assign bus.perm_done = (perm_cnt == 0) && !perm_hold;
  assign bus.tls_done  = (tls_cnt == 0);

  // Output-side monitor, sampled on the falling edge.
  xfer_t            xfer_q[$];
  logic [3:0]       upd_q[$];
  int               n_en_key = 0;
  int               n_sp = 0;
  int               n_st = 0;
  int               n_stall = 0;
  int               n_hold_err = 0;
  logic             prev_stall = 1'b0;
  logic [CTR_W-1:0] prev_idx = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (bus.en_key)     n_en_key <= n_en_key + 1;
      if (bus.start_perm) n_sp <= n_sp + 1;
      if (bus.start_tls)  n_st <= n_st + 1;
      if (bus.state_sel != 2'b00) upd_q.push_back({bus.state_sel, bus.dom_sep});
      if (bus.bdo_valid && bus.bdo_ready)
        xfer_q.push_back({bus.word_idx, bus.bdo_last, bus.end_of_block, bus.sel_tag});
      if (prev_stall && bus.bdo_valid && bus.word_idx != prev_idx)
        n_hold_err <= n_hold_err + 1;
      if (bus.bdo_valid && !bus.bdo_ready) n_stall <= n_stall + 1;
      prev_stall <= bus.bdo_valid && !bus.bdo_ready;
      prev_idx   <= bus.word_idx;
    end
  end

  // bdo_ready driver: steady high, or alternating when toggle_en is set.
  bit toggle_en = 1'b0;
  initial begin
    bus.bdo_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.bdo_ready = toggle_en ? ~bus.bdo_ready : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic put_key();
    int n = 0;
    bus.key_valid = 1'b1;
    while (!bus.key_ready && n < 50) begin tick(); n++; end
    check("key_ready", bus.key_ready, 1);
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic put_bdi(input logic eot, input logic eoi, input logic [3:0] typ,
                         input logic [2:0] size, input logic dec, input logic teq);
    int n = 0;
    bus.bdi_valid   = 1'b1;
    bus.bdi_eot     = eot;
    bus.bdi_eoi     = eoi;
    bus.bdi_type    = typ;
    bus.bdi_size    = size;
    bus.decrypt     = dec;
    bus.tag_word_eq = teq;
    while (!bus.bdi_ready && n < 100) begin tick(); n++; end
    check("bdi_ready", bus.bdi_ready, 1);
    tick();
    bus.bdi_valid = 1'b0;
    bus.bdi_eot   = 1'b0;
    bus.bdi_eoi   = 1'b0;
  endtask

  task automatic put_nonce(input logic dec, input logic eoi);
    for (int i = 0; i < 4; i++) put_bdi(1'b0, eoi && (i == 3), 4'h0, 3'd0, dec, 1'b0);
  endtask

  task automatic wait_bdo(input int target);
    int n = 0;
    while (xfer_q.size() < target && n < 300) begin tick(); n++; end
    check("bdo_count", xfer_q.size(), target);
  endtask

  task automatic check_xfer(string tag, input int pos, input int idx, input logic last,
                            input logic eob, input logic tsel);
    xfer_t x;
    x = xfer_q[pos];
    check($sformatf("%s[%0d]_idx", tag, pos), 32'(x.idx), idx);
    check($sformatf("%s[%0d]_flags", tag, pos), {x.last, x.eob, x.tag}, {last, eob, tsel});
  endtask

  task automatic check_idle(string tag);
    check({tag, "_clr"}, bus.clr_bdi, 1);
    check({tag, "_idx"}, 32'(bus.word_idx), 0);
    check({tag, "_outs"}, {bus.key_ready, bus.bdi_ready, bus.bdo_valid, bus.bdo_last,
                           bus.end_of_block, bus.msg_auth_valid, bus.msg_auth, bus.start_tls,
                           bus.start_perm, bus.en_key, bus.en_bdi, bus.en_pad,
                           bus.en_ext_state, bus.tweak_sel, bus.sel_tag, bus.state_sel,
                           bus.dom_sep}, 0);
  endtask

  task automatic wait_auth(input logic exp_auth, string tag);
    int n = 0;
    while (!bus.msg_auth_valid && n < 100) begin tick(); n++; end
    check({tag, "_valid"}, bus.msg_auth_valid, 1);
    check({tag, "_auth"}, bus.msg_auth, exp_auth);
    bus.msg_auth_ready = 1'b1;
    tick();
    bus.msg_auth_ready = 1'b0;
    check({tag, "_done"}, bus.msg_auth_valid, 0);
    check({tag, "_idle"}, bus.clr_bdi, 1);
  endtask

  int base;
  int upd_base;
  int sp0;
  int st0;

  initial begin
    bus.key_update     = 1'b0;
    bus.key_valid      = 1'b0;
    bus.bdi_valid      = 1'b0;
    bus.bdi_eot        = 1'b0;
    bus.bdi_eoi        = 1'b0;
    bus.bdi_type       = 4'h0;
    bus.bdi_size       = 3'd0;
    bus.decrypt        = 1'b0;
    bus.msg_auth_ready = 1'b0;
    bus.tag_word_eq    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("reset_idle");

    // Encrypt, fresh key, empty AD/message: only the tag comes out.
    base = xfer_q.size(); sp0 = n_sp; st0 = n_st; upd_base = upd_q.size();
    bus.key_update = 1'b1;
    repeat (4) put_key();
    bus.key_update = 1'b0;
    put_nonce(1'b0, 1'b1);
    wait_bdo(base + 4);
    for (int k = 0; k < 4; k++) check_xfer("t1_tag", base + k, k, k == 3, k == 3, 1'b1);
    check("t1_back_idle", bus.clr_bdi, 1);
    check("t1_en_key", n_en_key, 4);
    check("t1_start_tls", n_st - st0, 2);
    check("t1_start_perm", n_sp - sp0, 1);
    check("t1_no_update", upd_q.size(), upd_base);

    // Key reuse, 3 AD words (partial last), 8 message words, stalled output.
    base = xfer_q.size(); sp0 = n_sp; upd_base = upd_q.size();
    put_nonce(1'b0, 1'b0);
    put_bdi(1'b0, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0);
    put_bdi(1'b0, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0);
    put_bdi(1'b1, 1'b0, 4'b0001, 3'd2, 1'b0, 1'b0);
    toggle_en = 1'b1;
    for (int i = 0; i < 8; i++) put_bdi(i == 7, i == 7, 4'b0100, 3'd0, 1'b0, 1'b0);
    wait_bdo(base + 12);
    toggle_en = 1'b0;
    for (int k = 0; k < 8; k++) check_xfer("t2_msg", base + k, k, k == 7, k == 7, 1'b0);
    for (int k = 0; k < 4; k++) check_xfer("t2_tag", base + 8 + k, k, k == 3, k == 3, 1'b1);
    check("t2_upd_count", upd_q.size() - upd_base, 2);
    check("t2_upd_ad", upd_q[upd_base], 4'b0110);
    check("t2_upd_msg", upd_q[upd_base + 1], 4'b1101);
    check("t2_start_perm", n_sp - sp0, 3);
    check("t2_stalls_seen", n_stall != 0, 1);
    check("t2_idx_hold", n_hold_err, 0);
    check("t2_key_reused", n_en_key, 4);
    repeat (3) tick();
    check("t2_no_dup", xfer_q.size(), base + 12);

    // Decrypt, 2-word partial message, correct tag.
    base = xfer_q.size(); upd_base = upd_q.size();
    put_nonce(1'b1, 1'b0);
    put_bdi(1'b0, 1'b0, 4'b0100, 3'd0, 1'b0, 1'b0);
    put_bdi(1'b1, 1'b1, 4'b0100, 3'd3, 1'b0, 1'b0);
    wait_bdo(base + 2);
    for (int k = 0; k < 2; k++) check_xfer("t3_msg", base + k, k, k == 1, k == 1, 1'b0);
    check("t3_upd_dec", upd_q[upd_base], 4'b1011);
    for (int i = 0; i < 4; i++) put_bdi(i == 3, 1'b0, 4'b0101, 3'd0, 1'b0, 1'b1);
    wait_auth(1'b1, "t3_auth");
    check("t3_no_tag_out", xfer_q.size(), base + 2);

    // Decrypt, empty message, tag mismatch on word 2.
    base = xfer_q.size(); upd_base = upd_q.size();
    put_nonce(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) put_bdi(i == 3, 1'b0, 4'b0101, 3'd0, 1'b0, i != 2);
    wait_auth(1'b0, "t4_auth");
    check("t4_no_bdo", xfer_q.size(), base);
    check("t4_no_update", upd_q.size(), upd_base);

    // Reset while parked in WAIT_PERM, then a clean encrypt run.
    perm_hold = 1'b1;
    put_nonce(1'b0, 1'b0);
    put_bdi(1'b0, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0);
    put_bdi(1'b1, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0);
    repeat (2) tick();
    check("t5_wait_idx", 32'(bus.word_idx), 1);
    check("t5_wait_quiet", {bus.clr_bdi, bus.bdi_ready, bus.start_perm, bus.bdo_valid}, 0);
    rst = 1'b1;
    tick();
    check_idle("t5_reset");
    rst = 1'b0;
    perm_hold = 1'b0;
    base = xfer_q.size();
    put_nonce(1'b0, 1'b1);
    wait_bdo(base + 4);
    for (int k = 0; k < 4; k++) check_xfer("t5_tag", base + k, k, k == 3, k == 3, 1'b1);
    check("t5_key_reused", n_en_key, 4);
    check("t5_back_idle", bus.clr_bdi, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
